// File: rtl/answer_check_if.sv
// Keypad/secret inputs and entry/result outputs of answer_check, bundled.
// The locked signal exists only when LOCKOUT_EN is defined.
interface answer_check_if #(
  parameter int DIGITS = 4
);
  logic                  key_valid;
  logic [3:0]            key_code;
  logic [4*DIGITS-1:0]   secret;
  logic [4*DIGITS-1:0]   entry;
  logic [3:0]            digit_cnt;
  logic                  wrong;
  logic [3:0]            wrong_cnt;
  logic                  pass;
  logic                  fail;
`ifdef LOCKOUT_EN
  logic                  locked;
`endif

  modport master (
    output key_valid, key_code, secret,
    input  entry, digit_cnt, wrong, wrong_cnt, pass, fail
`ifdef LOCKOUT_EN
    , input locked
`endif
  );

  modport slave (
    input  key_valid, key_code, secret,
    output entry, digit_cnt, wrong, wrong_cnt, pass, fail
`ifdef LOCKOUT_EN
    , output locked
`endif
  );
endinterface

// File: rtl/answer_check.sv
// Keypad code checker: collects BCD digits, compares against secret, emits wrong strobe/count,
// sticky pass/fail. Define LOCKOUT_EN to add a post-miss LOCK state with a cycle counter.
module answer_check #(
  parameter int DIGITS      = 4,
  parameter int MAX_TRIES   = 10,
  parameter int LOCK_CYCLES = 50_000_000
) (
  input  logic           clk,
  input  logic           reset,
  answer_check_if.slave  bus
);

  localparam int         ENTRY_W   = 4 * DIGITS;
  localparam logic [3:0] LAST_IDX  = 4'(DIGITS - 1);
  localparam logic [3:0] TRY_LIMIT = 4'(MAX_TRIES);

  generate
    if (DIGITS < 1 || DIGITS > 8 || MAX_TRIES < 1 || MAX_TRIES > 15 || LOCK_CYCLES < 1) begin : g_bad_cfg
      $error("answer_check: parameter out of range");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_ENTRY = 3'd0,
    S_CHECK = 3'd1,
    S_PASS  = 3'd2,
    S_FAIL  = 3'd3
`ifdef LOCKOUT_EN
    , S_LOCK = 3'd4
`endif
  } state_t;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  state_t               state, state_nxt;
  logic [ENTRY_W-1:0]   entry_q, entry_next;
  logic [3:0]           digit_cnt_q;
  logic                 wrong_q;
  logic [3:0]           wrong_cnt_q;
  logic                 pass_q;
  logic                 fail_q;

  logic                 key_digit, key_clear;
  logic                 code_match, limit_hit;
  logic [3:0]           wrong_cnt_inc;
  logic                 shift_en, clear_en, miss, hit;

  assign key_digit     = bus.key_valid && (bus.key_code <= 4'd9);
  assign key_clear     = bus.key_valid && (bus.key_code == 4'hA);
  assign code_match    = (entry_q == bus.secret);
  assign wrong_cnt_inc = sat_inc(wrong_cnt_q);
  assign limit_hit     = (wrong_cnt_inc == TRY_LIMIT);

  generate
    if (DIGITS == 1) begin : g_shift_one
      assign entry_next = bus.key_code;
    end else begin : g_shift_many
      assign entry_next = {entry_q[ENTRY_W-5:0], bus.key_code};
    end
  endgenerate

`ifdef LOCKOUT_EN
  logic [31:0] lock_cnt;
  logic        lock_done;
  logic        lock_load;

  assign lock_done = (lock_cnt == 32'd0);
  assign lock_load = miss && !limit_hit;

  // Loaded on the wrong-strobe edge so ENTRY resumes LOCK_CYCLES edges later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_cnt <= 32'd0;
    end else if (lock_load) begin
      lock_cnt <= 32'(LOCK_CYCLES - 1);
    end else if (state == S_LOCK && !lock_done) begin
      lock_cnt <= lock_cnt - 32'd1;
    end
  end

  assign bus.locked = (state == S_LOCK);
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_ENTRY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_ENTRY: begin
        if (key_digit && digit_cnt_q == LAST_IDX) begin
          state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (code_match) begin
          state_nxt = S_PASS;
        end else if (limit_hit) begin
          state_nxt = S_FAIL;
        end else begin
`ifdef LOCKOUT_EN
          state_nxt = S_LOCK;
`else
          state_nxt = S_ENTRY;
`endif
        end
      end
`ifdef LOCKOUT_EN
      S_LOCK: begin
        if (lock_done) begin
          state_nxt = S_ENTRY;
        end
      end
`endif
      default: state_nxt = state;
    endcase
  end

  // Per-state action decode; PASS, FAIL and LOCK take no actions
  always_comb begin
    shift_en = 1'b0;
    clear_en = 1'b0;
    miss     = 1'b0;
    hit      = 1'b0;
    case (state)
      S_ENTRY: begin
        shift_en = key_digit;
        clear_en = key_clear;
      end
      S_CHECK: begin
        hit  = code_match;
        miss = !code_match;
      end
      default: ;
    endcase
  end

  // Registered outputs; wrong is a clean one-cycle pulse from a flop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_q     <= '0;
      digit_cnt_q <= 4'd0;
      wrong_q     <= 1'b0;
      wrong_cnt_q <= 4'd0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      wrong_q <= miss;
      if (shift_en) begin
        entry_q     <= entry_next;
        digit_cnt_q <= digit_cnt_q + 4'd1;
      end else if (clear_en || miss) begin
        entry_q     <= '0;
        digit_cnt_q <= 4'd0;
      end
      if (miss) begin
        wrong_cnt_q <= wrong_cnt_inc;
        if (limit_hit) begin
          fail_q <= 1'b1;
        end
      end
      if (hit) begin
        pass_q <= 1'b1;
      end
    end
  end

  assign bus.entry     = entry_q;
  assign bus.digit_cnt = digit_cnt_q;
  assign bus.wrong     = wrong_q;
  assign bus.wrong_cnt = wrong_cnt_q;
  assign bus.pass      = pass_q;
  assign bus.fail      = fail_q;

endmodule

// File: tb/tb_answer_check.sv
// Bench for answer_check: directed scenarios plus random key sequences against a digit-queue model.
module tb_answer_check;
  localparam int DIGITS      = 4;
  localparam int MAX_TRIES   = 3;
  localparam int LOCK_CYCLES = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  answer_check_if #(.DIGITS(DIGITS)) bus();

  answer_check #(
    .DIGITS      (DIGITS),
    .MAX_TRIES   (MAX_TRIES),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Model: entered digits, wrong count, terminal flags
  int m_q[$];
  int m_wc;
  bit m_pass, m_fail;

  function automatic logic [26:0] obs();
    return {bus.entry, bus.digit_cnt, bus.wrong, bus.wrong_cnt, bus.pass, bus.fail};
  endfunction

  function automatic logic [26:0] exp_vec(input bit strobe);
    logic [15:0] e;
    e = 16'h0;
    foreach (m_q[i]) e = (e << 4) | 16'(m_q[i]);
    return {e, 4'(m_q.size()), strobe, 4'(m_wc), m_pass, m_fail};
  endfunction

  task automatic model_key(input int c, output bit strobe);
    int val;
    strobe = 1'b0;
    if (m_pass || m_fail) return;
    if (c <= 9) begin
      m_q.push_back(c);
      if (m_q.size() == DIGITS) begin
        val = 0;
        foreach (m_q[i]) val = val * 16 + m_q[i];
        if (val == int'(bus.secret)) begin
          m_pass = 1'b1;
        end else begin
          strobe = 1'b1;
          m_wc   = (m_wc < 15) ? m_wc + 1 : 15;
          if (m_wc == MAX_TRIES) m_fail = 1'b1;
          m_q.delete();
        end
      end
    end else if (c == 10) begin
      m_q.delete();
    end
  endtask

  // Called at a negedge; returns at the negedge after the key edge
  task automatic press(input logic [3:0] c);
    bus.key_valid = 1'b1;
    bus.key_code  = c;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
  endtask

  task automatic enter4(input logic [15:0] v);
    for (int i = 3; i >= 0; i--) press(v[4*i +: 4]);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_unlock();
`ifdef LOCKOUT_EN
    repeat (LOCK_CYCLES) @(negedge clk);
`endif
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_total++;
    if (obs() !== 27'd0) $display("FAIL reset_state: got %h want %h", obs(), 27'd0);
    else n_pass++;
`ifdef LOCKOUT_EN
    n_total++;
    if (bus.locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", bus.locked);
    else n_pass++;
`endif
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_pass();
    enter4(16'h1234);
    n_total++;
    if ({bus.entry, bus.digit_cnt, bus.pass} !== {16'h1234, 4'd4, 1'b0})
      $display("FAIL pass_entry: got %h/%0d/%b want 1234/4/0", bus.entry, bus.digit_cnt, bus.pass);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({bus.pass, bus.wrong, bus.fail} !== 3'b100)
      $display("FAIL pass_flag: got pass/wrong/fail %b%b%b want 100", bus.pass, bus.wrong, bus.fail);
    else n_pass++;
    press(4'd5); press(4'hA); press(4'd1);
    @(negedge clk);
    n_total++;
    if (obs() !== {16'h1234, 4'd4, 1'b0, 4'd0, 1'b1, 1'b0})
      $display("FAIL pass_hold: got %h want %h", obs(), {16'h1234, 4'd4, 1'b0, 4'd0, 1'b1, 1'b0});
    else n_pass++;
    apply_reset();
  endtask

  task automatic test_wrong();
    enter4(16'h1235);
    n_total++;
    if ({bus.wrong, bus.digit_cnt} !== {1'b0, 4'd4})
      $display("FAIL wrong_early: got wrong %b cnt %0d want 0/4", bus.wrong, bus.digit_cnt);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (obs() !== {16'h0, 4'd0, 1'b1, 4'd1, 1'b0, 1'b0})
      $display("FAIL wrong_strobe: got %h want %h", obs(), {16'h0, 4'd0, 1'b1, 4'd1, 1'b0, 1'b0});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.wrong !== 1'b0) $display("FAIL wrong_width: got %b want 0", bus.wrong);
    else n_pass++;
    wait_unlock();
    press(4'd7);
    n_total++;
    if ({bus.entry, bus.digit_cnt} !== {16'h0007, 4'd1})
      $display("FAIL wrong_reentry: got %h/%0d want 0007/1", bus.entry, bus.digit_cnt);
    else n_pass++;
    apply_reset();
  endtask

  task automatic test_fail();
    for (int k = 0; k < 3; k++) begin
      enter4(16'h0000);
      @(negedge clk);
      n_total++;
      if ({bus.wrong, bus.wrong_cnt, bus.fail} !== {1'b1, 4'(k + 1), (k == 2)})
        $display("FAIL fail_try%0d: got wrong/cnt/fail %b/%0d/%b want 1/%0d/%b",
                 k, bus.wrong, bus.wrong_cnt, bus.fail, k + 1, (k == 2));
      else n_pass++;
      if (k < 2) wait_unlock();
    end
    @(negedge clk);
    enter4(16'h1234);
    @(negedge clk);
    n_total++;
    if ({bus.pass, bus.fail, bus.wrong_cnt, bus.wrong} !== {1'b0, 1'b1, 4'd3, 1'b0})
      $display("FAIL fail_terminal: got pass/fail/cnt/wrong %b/%b/%0d/%b want 0/1/3/0",
               bus.pass, bus.fail, bus.wrong_cnt, bus.wrong);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_total++;
    if (obs() !== 27'd0) $display("FAIL fail_async_reset: got %h want 0", obs());
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    enter4(16'h1234);
    @(negedge clk);
    n_total++;
    if ({bus.pass, bus.fail} !== 2'b10)
      $display("FAIL fail_then_pass: got pass/fail %b%b want 10", bus.pass, bus.fail);
    else n_pass++;
    apply_reset();
  endtask

  task automatic test_clear();
    press(4'd1); press(4'd2); press(4'hA);
    n_total++;
    if ({bus.entry, bus.digit_cnt} !== {16'h0, 4'd0})
      $display("FAIL clear_entry: got %h/%0d want 0/0", bus.entry, bus.digit_cnt);
    else n_pass++;
    press(4'd3); press(4'd4);
    n_total++;
    if ({bus.entry, bus.digit_cnt, bus.wrong_cnt} !== {16'h0034, 4'd2, 4'd0})
      $display("FAIL clear_resume: got %h/%0d/%0d want 0034/2/0", bus.entry, bus.digit_cnt, bus.wrong_cnt);
    else n_pass++;
    for (int c = 11; c <= 15; c++) press(4'(c));
    n_total++;
    if (obs() !== {16'h0034, 4'd2, 1'b0, 4'd0, 1'b0, 1'b0})
      $display("FAIL clear_ignore: got %h want %h", obs(), {16'h0034, 4'd2, 1'b0, 4'd0, 1'b0, 1'b0});
    else n_pass++;
    apply_reset();
  endtask

  task automatic test_reset_mid();
    press(4'd1); press(4'd2); press(4'd3);
    #2 reset = 1'b1;
    #1;
    n_total++;
    if (obs() !== 27'd0) $display("FAIL mid_async_reset: got %h want 0", obs());
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    press(4'd4);
    @(negedge clk);
    n_total++;
    if ({bus.entry, bus.digit_cnt, bus.wrong} !== {16'h0004, 4'd1, 1'b0})
      $display("FAIL mid_restart: got %h/%0d/%b want 0004/1/0", bus.entry, bus.digit_cnt, bus.wrong);
    else n_pass++;
    apply_reset();
    enter4(16'h1235);
    #1 reset = 1'b1;
    #1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_total++;
    if ({bus.wrong, bus.wrong_cnt} !== 5'd0)
      $display("FAIL check_abort: got wrong/cnt %b/%0d want 0/0", bus.wrong, bus.wrong_cnt);
    else n_pass++;
    enter4(16'h1234);
    @(negedge clk);
    n_total++;
    if (bus.pass !== 1'b1) $display("FAIL abort_then_pass: got %b want 1", bus.pass);
    else n_pass++;
    apply_reset();
  endtask

`ifdef LOCKOUT_EN
  task automatic test_lockout();
    int lock_n;
    enter4(16'h1235);
    n_total++;
    if (bus.locked !== 1'b0) $display("FAIL lock_early: got %b want 0", bus.locked);
    else n_pass++;
    @(negedge clk);
    lock_n = 0;
    if (bus.locked) lock_n++;
    press(4'd1);
    for (int i = 0; i < 20 && bus.locked; i++) begin
      lock_n++;
      @(negedge clk);
    end
    n_total++;
    if (lock_n !== LOCK_CYCLES) $display("FAIL lock_len: got %0d cycles want %0d", lock_n, LOCK_CYCLES);
    else n_pass++;
    n_total++;
    if ({bus.digit_cnt, bus.entry} !== {4'd0, 16'h0})
      $display("FAIL lock_key_ignored: got %0d/%h want 0/0000", bus.digit_cnt, bus.entry);
    else n_pass++;
    enter4(16'h1234);
    @(negedge clk);
    n_total++;
    if ({bus.pass, bus.wrong_cnt} !== {1'b1, 4'd1})
      $display("FAIL lock_then_pass: got pass/cnt %b/%0d want 1/1", bus.pass, bus.wrong_cnt);
    else n_pass++;
    apply_reset();
  endtask
`endif

  task automatic new_secret_reset();
    logic [15:0] s;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) s[4*i +: 4] = 4'($urandom_range(0, 9));
    bus.secret = s;
    m_q.delete();
    m_wc = 0; m_pass = 1'b0; m_fail = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random();
    int c;
    bit strobe;
    new_secret_reset();
    for (int i = 0; i < 200; i++) begin
      if (m_pass || m_fail) new_secret_reset();
      if ($urandom_range(0, 99) < 70) c = int'(bus.secret[4*(DIGITS - 1 - m_q.size()) +: 4]);
      else c = int'($urandom_range(0, 15));
      press(4'(c));
      model_key(c, strobe);
      @(negedge clk);
      n_total++;
      if (obs() !== exp_vec(strobe))
        $display("FAIL random_step%0d key %0d: got %h want %h", i, c, obs(), exp_vec(strobe));
      else n_pass++;
      if (strobe && !m_fail) wait_unlock();
    end
    bus.secret = 16'h1234;
    apply_reset();
  endtask

  initial begin
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    bus.secret    = 16'h1234;
    test_reset();
    test_pass();
    test_wrong();
    test_fail();
    test_clear();
    test_reset_mid();
`ifdef LOCKOUT_EN
    test_lockout();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: time limit reached after %0d checks", n_total);
    $fatal(1);
  end
endmodule
